// File: rtl/ipsxe_floating_point_pkg_v1_0.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ipsxe_floating_point_pkg_v1_0 : shared constants/types for the a/b/c/op join
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
package ipsxe_floating_point_pkg_v1_0;

  localparam int c_fifo_depth = 2;
  localparam int c_cnt_width  = 2;
  localparam int c_ptr_width  = $clog2(c_fifo_depth);

  typedef logic [c_cnt_width-1:0] cnt_t;
  typedef logic [c_ptr_width-1:0] ptr_t;

  function automatic cnt_t next_count(input cnt_t cnt, input logic push, input logic pop);
    return cnt + cnt_t'(push) - cnt_t'(pop);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipsxe_floating_point_chan_fifo_v1_0.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ipsxe_floating_point_chan_fifo_v1_0 : 2-entry channel buffer, registered ready
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module ipsxe_floating_point_chan_fifo_v1_0
  import ipsxe_floating_point_pkg_v1_0::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_ready,
  output logic             o_not_empty,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [c_fifo_depth];
  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  cnt_t             r_count;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  cnt_t             w_count_nxt;

  // Ready already reflects free space, so a push can never overwrite a live entry.
  assign w_push      = i_valid & r_ready;
  assign w_pop       = i_pop & (r_count != '0);
  assign w_count_nxt = next_count(r_count, w_push, w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
      for (int i = 0; i < c_fifo_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < cnt_t'(c_fifo_depth));
    end
  end

  assign o_ready     = r_ready;
  assign o_not_empty = (r_count != '0);
  assign o_data      = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ipsxe_floating_point_abcop_join_v1_0.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ipsxe_floating_point_abcop_join_v1_0 : joins a/b/c/op AXI4-Stream channels
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module ipsxe_floating_point_abcop_join_v1_0
  import ipsxe_floating_point_pkg_v1_0::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 8,
  parameter int HAS_C      = 1
) (
  input  logic                  i_aclk,
  input  logic                  i_rst,
  input  logic                  i_axi4s_a_tvalid,
  input  logic [DATA_WIDTH-1:0] i_axi4s_a_tdata,
  output logic                  o_axi4s_a_tready,
  input  logic                  i_axi4s_b_tvalid,
  input  logic [DATA_WIDTH-1:0] i_axi4s_b_tdata,
  output logic                  o_axi4s_b_tready,
  input  logic                  i_axi4s_c_tvalid,
  input  logic [DATA_WIDTH-1:0] i_axi4s_c_tdata,
  output logic                  o_axi4s_c_tready,
  input  logic                  i_axi4s_operation_tvalid,
  input  logic [OP_WIDTH-1:0]   i_axi4s_operation_tdata,
  output logic                  o_axi4s_operation_tready,
  output logic                  o_axi4s_abcop_tvalid,
  input  logic                  i_axi4s_abcop_tready,
  output logic [DATA_WIDTH-1:0] o_a_tdata,
  output logic [DATA_WIDTH-1:0] o_b_tdata,
  output logic [DATA_WIDTH-1:0] o_c_tdata,
  output logic [OP_WIDTH-1:0]   o_operation_tdata
);

  logic w_a_ne;
  logic w_b_ne;
  logic w_c_ne;
  logic w_op_ne;
  logic w_join_valid;
  logic w_pop;

  // Every present channel pops together, so a join is never partial.
  assign w_join_valid = w_a_ne & w_b_ne & w_c_ne & w_op_ne;
  assign w_pop        = w_join_valid & i_axi4s_abcop_tready;

  ipsxe_floating_point_chan_fifo_v1_0 #(.WIDTH(DATA_WIDTH)) u_fifo_a (
    .clk         (i_aclk),
    .rst         (i_rst),
    .i_valid     (i_axi4s_a_tvalid),
    .i_data      (i_axi4s_a_tdata),
    .i_pop       (w_pop),
    .o_ready     (o_axi4s_a_tready),
    .o_not_empty (w_a_ne),
    .o_data      (o_a_tdata)
  );

  ipsxe_floating_point_chan_fifo_v1_0 #(.WIDTH(DATA_WIDTH)) u_fifo_b (
    .clk         (i_aclk),
    .rst         (i_rst),
    .i_valid     (i_axi4s_b_tvalid),
    .i_data      (i_axi4s_b_tdata),
    .i_pop       (w_pop),
    .o_ready     (o_axi4s_b_tready),
    .o_not_empty (w_b_ne),
    .o_data      (o_b_tdata)
  );

  ipsxe_floating_point_chan_fifo_v1_0 #(.WIDTH(OP_WIDTH)) u_fifo_op (
    .clk         (i_aclk),
    .rst         (i_rst),
    .i_valid     (i_axi4s_operation_tvalid),
    .i_data      (i_axi4s_operation_tdata),
    .i_pop       (w_pop),
    .o_ready     (o_axi4s_operation_tready),
    .o_not_empty (w_op_ne),
    .o_data      (o_operation_tdata)
  );

  generate
    if (HAS_C != 0) begin : g_c_present
      ipsxe_floating_point_chan_fifo_v1_0 #(.WIDTH(DATA_WIDTH)) u_fifo_c (
        .clk         (i_aclk),
        .rst         (i_rst),
        .i_valid     (i_axi4s_c_tvalid),
        .i_data      (i_axi4s_c_tdata),
        .i_pop       (w_pop),
        .o_ready     (o_axi4s_c_tready),
        .o_not_empty (w_c_ne),
        .o_data      (o_c_tdata)
      );
    end else begin : g_c_absent
      // Absent c channel never gates the join and never accepts data.
      logic w_c_unused;
      assign w_c_unused       = ^{i_axi4s_c_tvalid, i_axi4s_c_tdata};
      assign w_c_ne           = 1'b1;
      assign o_c_tdata        = '0;
      assign o_axi4s_c_tready = 1'b0;
    end
  endgenerate

  assign o_axi4s_abcop_tvalid = w_join_valid;

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_abcop_join_v1_0.sv
`default_nettype none
// Scoreboard bench for the a/b/c/op join: a HAS_C=1 instance and a HAS_C=0 instance.
module tb_ipsxe_floating_point_abcop_join_v1_0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [7:0]  op;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // HAS_C=1 instance signals
  logic a_v = 0, b_v = 0, c_v = 0, o_v = 0;
  logic [31:0] a_d = 0, b_d = 0, c_d = 0;
  logic [7:0]  o_d = 0;
  logic a_r, b_r, c_r, o_r, out_v;
  logic [31:0] out_a, out_b, out_c;
  logic [7:0]  out_op;
  logic core_rdy = 0;

  // HAS_C=0 instance signals
  logic n_a_v = 0, n_b_v = 0, n_c_v = 0, n_o_v = 0;
  logic [31:0] n_a_d = 0, n_b_d = 0, n_c_d = 0;
  logic [7:0]  n_o_d = 0;
  logic n_a_r, n_b_r, n_c_r, n_o_r, n_out_v;
  logic [31:0] n_out_a, n_out_b, n_out_c;
  logic [7:0]  n_out_op;
  logic n_core_rdy = 0;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  beat_t q0[$];
  beat_t q1[$];
  int    pop_cyc[$];
  beat_t e0, e1;

  ipsxe_floating_point_abcop_join_v1_0 #(.DATA_WIDTH(32), .OP_WIDTH(8), .HAS_C(1)) dut (
    .i_aclk(clk), .i_rst(rst),
    .i_axi4s_a_tvalid(a_v), .i_axi4s_a_tdata(a_d), .o_axi4s_a_tready(a_r),
    .i_axi4s_b_tvalid(b_v), .i_axi4s_b_tdata(b_d), .o_axi4s_b_tready(b_r),
    .i_axi4s_c_tvalid(c_v), .i_axi4s_c_tdata(c_d), .o_axi4s_c_tready(c_r),
    .i_axi4s_operation_tvalid(o_v), .i_axi4s_operation_tdata(o_d), .o_axi4s_operation_tready(o_r),
    .o_axi4s_abcop_tvalid(out_v), .i_axi4s_abcop_tready(core_rdy),
    .o_a_tdata(out_a), .o_b_tdata(out_b), .o_c_tdata(out_c), .o_operation_tdata(out_op)
  );

  ipsxe_floating_point_abcop_join_v1_0 #(.DATA_WIDTH(32), .OP_WIDTH(8), .HAS_C(0)) dut_noc (
    .i_aclk(clk), .i_rst(rst),
    .i_axi4s_a_tvalid(n_a_v), .i_axi4s_a_tdata(n_a_d), .o_axi4s_a_tready(n_a_r),
    .i_axi4s_b_tvalid(n_b_v), .i_axi4s_b_tdata(n_b_d), .o_axi4s_b_tready(n_b_r),
    .i_axi4s_c_tvalid(n_c_v), .i_axi4s_c_tdata(n_c_d), .o_axi4s_c_tready(n_c_r),
    .i_axi4s_operation_tvalid(n_o_v), .i_axi4s_operation_tdata(n_o_d), .o_axi4s_operation_tready(n_o_r),
    .o_axi4s_abcop_tvalid(n_out_v), .i_axi4s_abcop_tready(n_core_rdy),
    .o_a_tdata(n_out_a), .o_b_tdata(n_out_b), .o_c_tdata(n_out_c), .o_operation_tdata(n_out_op)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitors: a beat transfers on the edge after a negedge with valid & ready.
  always @(negedge clk) begin
    if (!rst && out_v && core_rdy) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL c_unexpected_beat actual a=0x%0h required no beat", out_a);
      end else begin
        e0 = q0.pop_front();
        chk("c_beat_a", out_a, e0.a);
        chk("c_beat_b", out_b, e0.b);
        chk("c_beat_c", out_c, e0.c);
        chk("c_beat_op", {24'h0, out_op}, {24'h0, e0.op});
        pop_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && n_out_v && n_core_rdy) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL noc_unexpected_beat actual a=0x%0h required no beat", n_out_a);
      end else begin
        e1 = q1.pop_front();
        chk("noc_beat_a", n_out_a, e1.a);
        chk("noc_beat_b", n_out_b, e1.b);
        chk("noc_beat_c", n_out_c, 32'h0);
        chk("noc_beat_op", {24'h0, n_out_op}, {24'h0, e1.op});
      end
    end
  end

  // Presents one beat on every channel, dropping each valid once accepted.
  task automatic send0(input beat_t bt);
    bit pa = 1, pb = 1, pc = 1, po = 1;
    bit acc_a, acc_b, acc_c, acc_o;
    int guard = 0;
    q0.push_back(bt);
    a_d = bt.a; b_d = bt.b; c_d = bt.c; o_d = bt.op;
    while ((pa || pb || pc || po) && guard < 50) begin
      a_v = pa; b_v = pb; c_v = pc; o_v = po;
      @(negedge clk);
      acc_a = a_v & a_r; acc_b = b_v & b_r; acc_c = c_v & c_r; acc_o = o_v & o_r;
      @(posedge clk); #1;
      if (acc_a) pa = 0;
      if (acc_b) pb = 0;
      if (acc_c) pc = 0;
      if (acc_o) po = 0;
      guard++;
    end
    a_v = 0; b_v = 0; c_v = 0; o_v = 0;
    if (pa || pb || pc || po) begin
      checks++;
      failures++;
      $display("FAIL c_send_timeout actual=pending required=accepted");
    end
  endtask

  task automatic send1(input beat_t bt);
    bit pa = 1, pb = 1, po = 1;
    bit acc_a, acc_b, acc_o;
    int guard = 0;
    q1.push_back(bt);
    n_a_d = bt.a; n_b_d = bt.b; n_o_d = bt.op;
    while ((pa || pb || po) && guard < 50) begin
      n_a_v = pa; n_b_v = pb; n_o_v = po;
      @(negedge clk);
      acc_a = n_a_v & n_a_r; acc_b = n_b_v & n_b_r; acc_o = n_o_v & n_o_r;
      @(posedge clk); #1;
      if (acc_a) pa = 0;
      if (acc_b) pb = 0;
      if (acc_o) po = 0;
      guard++;
    end
    n_a_v = 0; n_b_v = 0; n_o_v = 0;
    if (pa || pb || po) begin
      checks++;
      failures++;
      $display("FAIL noc_send_timeout actual=pending required=accepted");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gaps;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {31'h0, out_v}, 32'h0);
    chk("rst_treadies", {28'h0, a_r, b_r, c_r, o_r}, 32'h0);
    chk("rst_tdata_a", out_a, 32'h0);
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_treadies", {28'h0, a_r, b_r, c_r, o_r}, 32'hF);
    chk("post_rst_noc_treadies", {29'h0, n_a_r, n_b_r, n_o_r}, 32'h7);

    // Single beat, one-cycle latency
    core_rdy = 1;
    send0('{32'h3F800000, 32'h40000000, 32'h40400000, 8'h01});
    chk("single_latency_tvalid", {31'h0, out_v}, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    // c arrives five cycles late
    q0.push_back('{32'h11111111, 32'h22222222, 32'h33333333, 8'h05});
    a_d = 32'h11111111; b_d = 32'h22222222; c_d = 32'h33333333; o_d = 8'h05;
    a_v = 1; b_v = 1; o_v = 1; c_v = 0;
    @(posedge clk); #1;
    a_v = 0; b_v = 0; o_v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_c_tvalid_low", {31'h0, out_v}, 32'h0);
      chk("late_c_abop_ready", {29'h0, a_r, b_r, o_r}, 32'h7);
      @(posedge clk); #1;
    end
    c_v = 1;
    @(posedge clk); #1;
    c_v = 0;
    chk("late_c_tvalid_high", {31'h0, out_v}, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: fill both entries, hold, then release
    core_rdy = 0;
    send0('{32'hA0000001, 32'hB0000001, 32'hC0000001, 8'h11});
    send0('{32'hA0000002, 32'hB0000002, 32'hC0000002, 8'h12});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_treadies_low", {28'h0, a_r, b_r, c_r, o_r}, 32'h0);
      chk("stall_tvalid_held", {31'h0, out_v}, 32'h1);
      chk("stall_payload_a", out_a, 32'hA0000001);
      chk("stall_payload_op", {24'h0, out_op}, 32'h11);
      @(posedge clk); #1;
    end
    core_rdy = 1;
    send0('{32'hA0000003, 32'hB0000003, 32'hC0000003, 8'h13});
    send0('{32'hA0000004, 32'hB0000004, 32'hC0000004, 8'h14});
    repeat (4) @(posedge clk);
    #1;

    // Continuous streaming of 16 beats
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      send0('{32'(i), 32'(i + 100), 32'(i + 200), 8'(i)});
    end
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count", pop_cyc.size(), 32'd16);
    gaps = 0;
    for (int i = 1; i < pop_cyc.size(); i++) begin
      if (pop_cyc[i] - pop_cyc[i-1] != 1) gaps++;
    end
    chk("stream_gaps", gaps, 32'd0);

    // Reset with two entries buffered
    core_rdy = 0;
    send0('{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 8'hE1});
    send0('{32'hDEAD0011, 32'hDEAD0012, 32'hDEAD0013, 8'hE2});
    rst = 1;
    q0.delete();
    core_rdy = 1;
    a_v = 1; b_v = 1; c_v = 1; o_v = 1;
    @(posedge clk); #1;
    chk("midrst_tvalid", {31'h0, out_v}, 32'h0);
    chk("midrst_treadies", {28'h0, a_r, b_r, c_r, o_r}, 32'h0);
    chk("midrst_tdata_c", out_c, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    a_v = 0; b_v = 0; c_v = 0; o_v = 0;
    @(posedge clk); #1;
    chk("midrst_release_treadies", {28'h0, a_r, b_r, c_r, o_r}, 32'hF);
    chk("midrst_release_tvalid", {31'h0, out_v}, 32'h0);
    repeat (4) @(posedge clk);
    #1;

    // HAS_C=0 instance
    n_core_rdy = 1;
    send1('{32'h40A00000, 32'h40C00000, 32'hFFFFFFFF, 8'h02});
    chk("noc_latency_tvalid", {31'h0, n_out_v}, 32'h1);
    send1('{32'h00000001, 32'h00000002, 32'hFFFFFFFF, 8'h03});
    repeat (4) @(posedge clk);
    #1;

    chk("c_drain_empty", q0.size(), 32'd0);
    chk("noc_drain_empty", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
